// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath widths, PC increment and the
// fetch-stage state encoding.
package proc_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'b00111000100000000000000000000000;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, waits RD_WAIT cycles for memory to
// settle, then presents word+PC to decode and honours taken-branch redirects.
//
// Handshake: id_valid/id_instr/id_pc form a valid/ready pair. Once id_valid is
// high the payload holds until a cycle with id_ready=1 (transfer); a redirect
// withdraws it (flush). id_valid never depends combinationally on id_ready.
module if_fetch_unit
  import proc_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
  parameter int                RD_WAIT  = 0,
  parameter int                MEM_SIZE = 40
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_instr,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [ADDR_W-1:0]   id_pc,
  input  logic                br_taken,
  input  logic [ADDR_W-1:0]   br_target,
  output logic                fetch_fault,
  output fetch_state_t        dbg_state
);

  localparam logic [3:0]        WAIT_MAX  = 4'(RD_WAIT);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = 32'(MEM_SIZE);

  logic [ADDR_W-1:0]  r_pc;
  logic [3:0]         r_wait_cnt;
  fetch_state_t       r_state;
  logic               r_id_valid;
  logic [INSTR_W-1:0] r_id_instr;
  logic [ADDR_W-1:0]  r_id_pc;
  logic               r_fault;

  logic w_in_fetch;
  logic w_wait_done;
  logic w_stall;
  logic w_redirect;
  logic w_capture;
  logic w_consume;
  logic w_out_of_range;
  logic w_misaligned;

  assign w_in_fetch     = (r_state == FETCH);
  assign w_wait_done    = (r_wait_cnt == WAIT_MAX);
  assign w_stall        = r_id_valid & ~id_ready;
  assign w_redirect     = w_in_fetch & br_taken;
  // Branch beats both capture and consume in the same cycle.
  assign w_capture      = w_in_fetch & w_wait_done & ~br_taken & ~w_stall;
  assign w_consume      = w_in_fetch & ~br_taken & r_id_valid & id_ready & ~w_capture;
  assign w_out_of_range = (r_pc >= MEM_LIMIT);
  assign w_misaligned   = (br_target[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_wait_cnt <= 4'd0;
      r_state    <= FETCH;
      r_id_valid <= 1'b0;
      r_id_instr <= '0;
      r_id_pc    <= '0;
      r_fault    <= 1'b0;
    end else if (w_redirect) begin
      r_wait_cnt <= 4'd0;
      r_id_valid <= 1'b0;
      // A misaligned target faults without moving the PC, so imem_addr freezes.
      if (w_misaligned) begin
        r_state <= FAULT;
        r_fault <= 1'b1;
      end else begin
        r_pc <= br_target;
      end
    end else if (w_capture) begin
      if (w_out_of_range) begin
        r_state    <= FAULT;
        r_fault    <= 1'b1;
        r_id_valid <= 1'b0;
      end else begin
        r_id_instr <= imem_instr;
        r_id_pc    <= r_pc;
        r_id_valid <= 1'b1;
        r_pc       <= r_pc + PC_STEP;
        r_wait_cnt <= 4'd0;
      end
    end else if (w_in_fetch) begin
      if (w_consume) begin
        r_id_valid <= 1'b0;
      end
      // The settle counter is frozen while decode is stalled.
      if (!w_stall && !w_wait_done) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc       = r_id_pc;
  assign fetch_fault = r_fault;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural model + per-cycle compare on the main
// instance, directed literal checks on RD_WAIT=2 and MEM_SIZE=20 instances.
module tb_if_fetch_unit;
  import proc_pkg::*;

  int total = 0;
  int bad   = 0;

  // Clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset     = 1'b1;
  logic        id_ready  = 1'b1;
  logic        br_taken  = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        reset2    = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int size);
    if (a < 32'(size)) return 32'h58000001 + (a << 16);
    return 32'hDEADBEEF;
  endfunction

  // Main instance: RD_WAIT=0, MEM_SIZE=40
  logic [31:0]  a_addr, a_instr, a_id_instr, a_id_pc;
  logic         a_valid, a_fault;
  fetch_state_t a_state;
  assign a_instr = mem_word(a_addr, 40);

  if_fetch_unit #(.RESET_PC(32'd0), .RD_WAIT(0), .MEM_SIZE(40)) u_main (
    .clk(clk), .reset(reset), .imem_addr(a_addr), .imem_instr(a_instr),
    .id_valid(a_valid), .id_ready(id_ready), .id_instr(a_id_instr), .id_pc(a_id_pc),
    .br_taken(br_taken), .br_target(br_target), .fetch_fault(a_fault), .dbg_state(a_state)
  );

  // Slow memory instance: RD_WAIT=2
  logic [31:0]  w_addr, w_instr, w_id_instr, w_id_pc;
  logic         w_valid, w_fault;
  fetch_state_t w_state;
  assign w_instr = mem_word(w_addr, 40);

  if_fetch_unit #(.RESET_PC(32'd0), .RD_WAIT(2), .MEM_SIZE(40)) u_wait2 (
    .clk(clk), .reset(reset2), .imem_addr(w_addr), .imem_instr(w_instr),
    .id_valid(w_valid), .id_ready(1'b1), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .br_taken(1'b0), .br_target(32'd0), .fetch_fault(w_fault), .dbg_state(w_state)
  );

  // Small memory instance: MEM_SIZE=20
  logic [31:0]  s_addr, s_instr, s_id_instr, s_id_pc;
  logic         s_valid, s_fault;
  fetch_state_t s_state;
  assign s_instr = mem_word(s_addr, 20);

  if_fetch_unit #(.RESET_PC(32'd0), .RD_WAIT(0), .MEM_SIZE(20)) u_mem20 (
    .clk(clk), .reset(reset2), .imem_addr(s_addr), .imem_instr(s_instr),
    .id_valid(s_valid), .id_ready(1'b1), .id_instr(s_id_instr), .id_pc(s_id_pc),
    .br_taken(1'b0), .br_target(32'd0), .fetch_fault(s_fault), .dbg_state(s_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the main instance: with no settle time, a word is
  // taken whenever the output slot is empty or being drained.
  logic [31:0] m_pc = 0, m_instr = 0, m_idpc = 0;
  logic        m_valid = 0, m_fault = 0;
  logic [31:0] exp_q[$];  // id_pc values expected to be handed to decode

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_idpc = 0; m_fault = 0;
    end else if (!m_fault) begin
      if (br_taken) begin
        m_valid = 0;
        if (br_target % 4 != 0) m_fault = 1;
        else m_pc = br_target;
      end else if (!m_valid || id_ready) begin
        if (m_pc >= 40) begin
          m_fault = 1; m_valid = 0;
        end else begin
          m_instr = mem_word(m_pc, 40);
          m_idpc  = m_pc;
          m_valid = 1;
          m_pc    = m_pc + 4;
        end
      end
    end
  end

  // Compare process
  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", {31'd0, a_valid}, {31'd0, m_valid});
      check("m_addr",  a_addr,           m_pc);
      check("m_fault", {31'd0, a_fault}, {31'd0, m_fault});
      check("m_state", {31'd0, a_state == FAULT}, {31'd0, m_fault});
      check("m_idpc",  a_id_pc,  m_idpc);
      check("m_instr", a_id_instr, m_instr);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] last_pc;

    // Reset state
    cyc(); cyc();
    chk_en = 1'b1;
    check("rst_valid", {31'd0, a_valid}, 32'd0);
    check("rst_addr",  a_addr, 32'd0);
    check("rst_fault", {31'd0, a_fault}, 32'd0);
    check("rst_idpc",  a_id_pc, 32'd0);
    check("rst_instr", a_id_instr, 32'd0);

    // Steady fetch: 0,4,8,12,16 on consecutive cycles
    reset = 1'b0;
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("seq_valid", {31'd0, a_valid}, 32'd1);
      check("seq_pc", a_id_pc, exp_q.pop_front());
    end
    check("seq_word0_model", mem_word(32'd0, 40), 32'h58000001);

    // Stall after the PC-4 capture
    reset = 1'b1; cyc(); reset = 1'b0;
    cyc();
    check("pc0_instr", a_id_instr, 32'h58000001);
    cyc();
    check("pc4_pc", a_id_pc, 32'd4);
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("stall_pc",    a_id_pc, 32'd4);
      check("stall_instr", a_id_instr, 32'h58040001);
      check("stall_addr",  a_addr, 32'd8);
      check("stall_valid", {31'd0, a_valid}, 32'd1);
    end
    id_ready = 1'b1;
    cyc();
    check("post_stall_pc", a_id_pc, 32'd8);
    check("post_stall_instr", a_id_instr, 32'h58080001);
    cyc();
    check("pre_br_pc", a_id_pc, 32'd12);

    // Redirect coinciding with a capture: branch wins
    br_taken = 1'b1; br_target = 32'd4;
    cyc();
    br_taken = 1'b0;
    check("br_valid", {31'd0, a_valid}, 32'd0);
    check("br_addr",  a_addr, 32'd4);
    cyc();
    check("br_cap_valid", {31'd0, a_valid}, 32'd1);
    check("br_cap_pc", a_id_pc, 32'd4);

    // Misaligned redirect faults; later redirects ignored
    br_taken = 1'b1; br_target = 32'd6;
    cyc();
    check("flt_fault", {31'd0, a_fault}, 32'd1);
    check("flt_valid", {31'd0, a_valid}, 32'd0);
    check("flt_addr",  a_addr, 32'd8);
    br_target = 32'd0; id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("flt_hold_fault", {31'd0, a_fault}, 32'd1);
      check("flt_hold_valid", {31'd0, a_valid}, 32'd0);
      check("flt_hold_addr",  a_addr, 32'd8);
    end
    br_taken = 1'b0; id_ready = 1'b1;
    reset = 1'b1;
    cyc();
    check("clr_fault", {31'd0, a_fault}, 32'd0);
    check("clr_addr",  a_addr, 32'd0);
    reset = 1'b0;
    cyc();
    check("resume_pc", a_id_pc, 32'd0);
    check("resume_valid", {31'd0, a_valid}, 32'd1);

    // Run to the end of the 40-byte memory
    last_pc = a_id_pc;
    for (int i = 0; i < 15 && !a_fault; i++) begin
      cyc();
      if (a_valid) last_pc = a_id_pc;
    end
    check("end_fault", {31'd0, a_fault}, 32'd1);
    check("end_last_pc", last_pc, 32'd36);
    check("end_addr", a_addr, 32'd40);
    chk_en = 1'b0;

    // RD_WAIT=2 and MEM_SIZE=20 instances
    reset2 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      check("w2_valid", {31'd0, w_valid}, {31'd0, (n % 3) == 0});
      check("w2_addr",  w_addr, 32'(4 * (n / 3)));
      if ((n % 3) == 0) begin
        check("w2_pc",    w_id_pc, 32'(4 * (n / 3 - 1)));
        check("w2_instr", w_id_instr, mem_word(32'(4 * (n / 3 - 1)), 40));
      end
      if (n <= 5) begin
        check("m20_valid", {31'd0, s_valid}, 32'd1);
        check("m20_pc",    s_id_pc, 32'(4 * (n - 1)));
        check("m20_fault", {31'd0, s_fault}, 32'd0);
      end else begin
        check("m20_oob_valid", {31'd0, s_valid}, 32'd0);
        check("m20_oob_fault", {31'd0, s_fault}, 32'd1);
        check("m20_oob_addr",  s_addr, 32'd20);
        check("m20_oob_pc",    s_id_pc, 32'd16);
      end
    end
    check("w2_fault", {31'd0, w_fault}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
